// File: rtl/phy_link_ctrl_if.sv
// Request/response MDIO master channel between the PHY link controller and
// the MDIO engine that serialises each access onto the MDC/MDIO pins.
interface phy_link_ctrl_if;
   logic        mdio_req_valid;
   logic        mdio_req_ready;
   logic        mdio_req_write;
   logic [4:0]  mdio_req_phy;
   logic [4:0]  mdio_req_reg;
   logic [15:0] mdio_req_wdata;
   logic        mdio_rsp_valid;
   logic [15:0] mdio_rsp_rdata;

   modport master (
      output mdio_req_valid,
      input  mdio_req_ready,
      output mdio_req_write,
      output mdio_req_phy,
      output mdio_req_reg,
      output mdio_req_wdata,
      input  mdio_rsp_valid,
      input  mdio_rsp_rdata
   );

   modport slave (
      input  mdio_req_valid,
      output mdio_req_ready,
      input  mdio_req_write,
      input  mdio_req_phy,
      input  mdio_req_reg,
      input  mdio_req_wdata,
      output mdio_rsp_valid,
      output mdio_rsp_rdata
   );
endinterface

// File: rtl/phy_link_ctrl.sv
// Ethernet PHY bring-up sequencer: hardware reset, control-register write,
// then periodic status polling that drives the MAC speed strobes and link flag.
module phy_link_ctrl #(
   parameter int unsigned RST_CYCLES  = 500000,
   parameter int unsigned WAIT_CYCLES = 250000,
   parameter int unsigned POLL_CYCLES = 5000000,
   parameter int unsigned RSP_TIMEOUT = 4096,
   parameter logic [4:0]  PHY_ADDR    = 5'h10,
   parameter logic [15:0] CFG_WORD    = 16'h1340
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic phy_rst_n,
   phy_link_ctrl_if.master mdio,
   output logic link_up,
   output logic set_10,
   output logic set_1000,
   output logic timeout_err
);

   localparam logic [2:0] ST_PHY_RST  = 3'd0;
   localparam logic [2:0] ST_WAIT     = 3'd1;
   localparam logic [2:0] ST_CFG_REQ  = 3'd2;
   localparam logic [2:0] ST_CFG_RSP  = 3'd3;
   localparam logic [2:0] ST_IDLE     = 3'd4;
   localparam logic [2:0] ST_POLL_REQ = 3'd5;
   localparam logic [2:0] ST_POLL_RSP = 3'd6;

   localparam logic [4:0] REG_CTRL   = 5'd0;
   localparam logic [4:0] REG_STATUS = 5'd17;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned CNT_MAX = max2(max2(RST_CYCLES, WAIT_CYCLES),
                                          max2(POLL_CYCLES, RSP_TIMEOUT));
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_CYCLES - 1);
   localparam logic [CNT_W-1:0] RSP_LOAD  = CNT_W'(RSP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // Resolved status decode: {link_up, set_1000, set_10}; speed strobes hold
   // their last value whenever the PHY reports no usable link.
   function automatic logic [2:0] decode_status(input logic [1:0] speed,
                                                input logic       resolved,
                                                input logic       link,
                                                input logic       s1000_prev,
                                                input logic       s10_prev);
      logic [2:0] r;
      if (resolved && link && (speed != 2'b11)) begin
         r = {1'b1, (speed == 2'b10), (speed == 2'b00)};
      end else begin
         r = {1'b0, s1000_prev, s10_prev};
      end
      return r;
   endfunction

   logic [2:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pending_r;
   logic             phy_rst_n_r;
   logic             req_valid_r;
   logic             req_write_r;
   logic [4:0]       req_reg_r;
   logic [15:0]      req_wdata_r;
   logic             link_up_r;
   logic             set_10_r;
   logic             set_1000_r;
   logic             timeout_err_r;

   logic cnt_zero_s;
   logic accept_s;
   logic restart_go_s;

   assign cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});
   assign accept_s     = req_valid_r & mdio.mdio_req_ready;
   // A restart may only take effect when no request is left dangling on the bus.
   assign restart_go_s = (restart | pending_r) & (~req_valid_r | mdio.mdio_req_ready);

   // Sequencer state, shared down-counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_PHY_RST;
         cnt_r         <= RST_LOAD;
         pending_r     <= 1'b0;
         phy_rst_n_r   <= 1'b0;
         req_valid_r   <= 1'b0;
         req_write_r   <= 1'b0;
         req_reg_r     <= 5'd0;
         req_wdata_r   <= 16'h0000;
         link_up_r     <= 1'b0;
         set_10_r      <= 1'b0;
         set_1000_r    <= 1'b0;
         timeout_err_r <= 1'b0;
      end else if (restart_go_s) begin
         state_r       <= ST_PHY_RST;
         cnt_r         <= RST_LOAD;
         pending_r     <= 1'b0;
         phy_rst_n_r   <= 1'b0;
         req_valid_r   <= 1'b0;
         req_write_r   <= 1'b0;
         req_reg_r     <= 5'd0;
         req_wdata_r   <= 16'h0000;
         link_up_r     <= 1'b0;
         set_10_r      <= 1'b0;
         set_1000_r    <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         pending_r <= pending_r | restart;
         case (state_r)
            ST_PHY_RST: begin
               if (cnt_zero_s) begin
                  state_r     <= ST_WAIT;
                  phy_rst_n_r <= 1'b1;
                  cnt_r       <= WAIT_LOAD;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_WAIT: begin
               if (cnt_zero_s) begin
                  state_r     <= ST_CFG_REQ;
                  req_valid_r <= 1'b1;
                  req_write_r <= 1'b1;
                  req_reg_r   <= REG_CTRL;
                  req_wdata_r <= CFG_WORD;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_CFG_REQ: begin
               if (accept_s) begin
                  state_r     <= ST_CFG_RSP;
                  req_valid_r <= 1'b0;
                  cnt_r       <= RSP_LOAD;
               end
            end
            ST_CFG_RSP: begin
               if (mdio.mdio_rsp_valid) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= POLL_LOAD;
               end else if (cnt_zero_s) begin
                  state_r       <= ST_IDLE;
                  cnt_r         <= POLL_LOAD;
                  timeout_err_r <= 1'b1;
                  link_up_r     <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_IDLE: begin
               if (cnt_zero_s) begin
                  state_r     <= ST_POLL_REQ;
                  req_valid_r <= 1'b1;
                  req_write_r <= 1'b0;
                  req_reg_r   <= REG_STATUS;
                  req_wdata_r <= 16'h0000;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_POLL_REQ: begin
               if (accept_s) begin
                  state_r     <= ST_POLL_RSP;
                  req_valid_r <= 1'b0;
                  cnt_r       <= RSP_LOAD;
               end
            end
            ST_POLL_RSP: begin
               if (mdio.mdio_rsp_valid) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= POLL_LOAD;
                  {link_up_r, set_1000_r, set_10_r} <=
                     decode_status(mdio.mdio_rsp_rdata[15:14], mdio.mdio_rsp_rdata[11],
                                   mdio.mdio_rsp_rdata[10], set_1000_r, set_10_r);
               end else if (cnt_zero_s) begin
                  state_r       <= ST_IDLE;
                  cnt_r         <= POLL_LOAD;
                  timeout_err_r <= 1'b1;
                  link_up_r     <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r     <= ST_PHY_RST;
               cnt_r       <= RST_LOAD;
               phy_rst_n_r <= 1'b0;
               req_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign phy_rst_n           = phy_rst_n_r;
   assign mdio.mdio_req_valid = req_valid_r;
   assign mdio.mdio_req_write = req_write_r;
   assign mdio.mdio_req_phy   = PHY_ADDR;
   assign mdio.mdio_req_reg   = req_reg_r;
   assign mdio.mdio_req_wdata = req_wdata_r;
   assign link_up             = link_up_r;
   assign set_10              = set_10_r;
   assign set_1000            = set_1000_r;
   assign timeout_err         = timeout_err_r;

endmodule
